// File: rtl/ldpc_frame_sequencer.sv
// Multi-frame BER test sequencer between the CSR block and the LDPC encoder/decoder wrappers.
// Optional macro LDPC_SEQ_BITERR_EN adds residual bit-error accumulation into bit_err_cnt.
module ldpc_frame_sequencer #(
   parameter int NN      = 208,
   parameter int MM      = 168,
   parameter int CNT_W   = 32,
   parameter int ENC_LAT = 4
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start,
   input  logic                 stop,
   input  logic [CNT_W-1:0]     cfg_frames,
   input  logic [NN-MM-1:0]     cfg_payload_base,
   input  logic [NN-1:0]        cfg_err_mask,
   input  logic                 cfg_rotate,
   input  logic [CNT_W-1:0]     cfg_timeout,
   output logic [NN-MM-1:0]     enc_y_in,
   input  logic [NN-1:0]        enc_cw,
   input  logic                 enc_valid,
   output logic [NN-1:0]        dec_q0_0,
   output logic [NN-1:0]        dec_q0_1,
   output logic                 dec_start,
   input  logic                 dec_done,
   input  logic [NN-1:0]        dec_y,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_W-1:0]     frame_cnt,
   output logic [CNT_W-1:0]     pass_cnt,
   output logic [CNT_W-1:0]     fail_cnt,
   output logic [CNT_W-1:0]     timeout_cnt,
   output logic [CNT_W-1:0]     bit_err_cnt
);

   localparam int K = NN - MM;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ENC_WAIT,
      ST_DEC_START,
      ST_DEC_WAIT,
      ST_CHECK,
      ST_DONE
   } state_t;

   state_t            state_q, state_d;
   logic              start_q, start_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [K-1:0]      payload_q, payload_d;
   logic [NN-1:0]     mask_q, mask_d;
   logic [NN-1:0]     cw_q, cw_d;
   logic [NN-1:0]     q0_0_q, q0_0_d;
   logic [NN-1:0]     q0_1_q, q0_1_d;
   logic              timed_out_q, timed_out_d;
   logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
   logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
   logic [CNT_W-1:0]  timeout_cnt_q, timeout_cnt_d;

   logic              start_edge;
   logic              timeout_hit;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

`ifdef LDPC_SEQ_BITERR_EN
   logic [CNT_W-1:0]  bit_err_cnt_q, bit_err_cnt_d;
   logic [NN-1:0]     err_vec;
   logic [CNT_W-1:0]  err_pop;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   always_comb begin
      err_vec = dec_y ^ cw_q;
      err_pop = '0;
      for (int i = 0; i < NN; i++) begin
         err_pop = err_pop + CNT_W'(err_vec[i]);
      end
   end
`endif

   assign start_edge  = start & ~start_q;
   assign timeout_hit = (cfg_timeout != '0) && (wait_cnt_q == cfg_timeout);

   always_comb begin
      state_d       = state_q;
      start_d       = start;
      wait_cnt_d    = wait_cnt_q;
      payload_d     = payload_q;
      mask_d        = mask_q;
      cw_d          = cw_q;
      q0_0_d        = q0_0_q;
      q0_1_d        = q0_1_q;
      timed_out_d   = timed_out_q;
      frame_cnt_d   = frame_cnt_q;
      pass_cnt_d    = pass_cnt_q;
      fail_cnt_d    = fail_cnt_q;
      timeout_cnt_d = timeout_cnt_q;
`ifdef LDPC_SEQ_BITERR_EN
      bit_err_cnt_d = bit_err_cnt_q;
`endif

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_edge) begin
               frame_cnt_d   = '0;
               pass_cnt_d    = '0;
               fail_cnt_d    = '0;
               timeout_cnt_d = '0;
`ifdef LDPC_SEQ_BITERR_EN
               bit_err_cnt_d = '0;
`endif
               payload_d     = cfg_payload_base;
               mask_d        = cfg_err_mask;
               wait_cnt_d    = '0;
               timed_out_d   = 1'b0;
               state_d       = ST_ENC_WAIT;
            end
         end

         ST_ENC_WAIT: begin
            wait_cnt_d = sat_inc(wait_cnt_q);
            // Decoder inputs are captured together with the codeword so they hold from DEC_START onward.
            if ((wait_cnt_q >= CNT_W'(ENC_LAT)) && enc_valid) begin
               cw_d    = enc_cw;
               q0_1_d  = enc_cw ^ mask_q;
               q0_0_d  = ~(enc_cw ^ mask_q);
               state_d = ST_DEC_START;
            end else if (timeout_hit) begin
               timed_out_d = 1'b1;
               state_d     = ST_CHECK;
            end
         end

         ST_DEC_START: begin
            wait_cnt_d = '0;
            state_d    = ST_DEC_WAIT;
         end

         ST_DEC_WAIT: begin
            wait_cnt_d = sat_inc(wait_cnt_q);
            if (dec_done) begin
               state_d = ST_CHECK;
            end else if (timeout_hit) begin
               timed_out_d = 1'b1;
               state_d     = ST_CHECK;
            end
         end

         ST_CHECK: begin
            frame_cnt_d = sat_inc(frame_cnt_q);
            if (timed_out_q) begin
               fail_cnt_d    = sat_inc(fail_cnt_q);
               timeout_cnt_d = sat_inc(timeout_cnt_q);
            end else if (dec_y == cw_q) begin
               pass_cnt_d = sat_inc(pass_cnt_q);
            end else begin
               fail_cnt_d = sat_inc(fail_cnt_q);
            end
`ifdef LDPC_SEQ_BITERR_EN
            if (!timed_out_q) begin
               bit_err_cnt_d = sat_add(bit_err_cnt_q, err_pop);
            end
`endif
            payload_d   = payload_q + K'(1);
            if (cfg_rotate) begin
               mask_d = {mask_q[NN-2:0], mask_q[NN-1]};
            end
            timed_out_d = 1'b0;
            wait_cnt_d  = '0;
            if (stop || ((cfg_frames != '0) && (frame_cnt_d == cfg_frames))) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_ENC_WAIT;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= ST_IDLE;
         start_q       <= 1'b0;
         wait_cnt_q    <= '0;
         payload_q     <= '0;
         mask_q        <= '0;
         cw_q          <= '0;
         q0_0_q        <= '1;
         q0_1_q        <= '0;
         timed_out_q   <= 1'b0;
         frame_cnt_q   <= '0;
         pass_cnt_q    <= '0;
         fail_cnt_q    <= '0;
         timeout_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         start_q       <= start_d;
         wait_cnt_q    <= wait_cnt_d;
         payload_q     <= payload_d;
         mask_q        <= mask_d;
         cw_q          <= cw_d;
         q0_0_q        <= q0_0_d;
         q0_1_q        <= q0_1_d;
         timed_out_q   <= timed_out_d;
         frame_cnt_q   <= frame_cnt_d;
         pass_cnt_q    <= pass_cnt_d;
         fail_cnt_q    <= fail_cnt_d;
         timeout_cnt_q <= timeout_cnt_d;
      end
   end

`ifdef LDPC_SEQ_BITERR_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bit_err_cnt_q <= '0;
      end else begin
         bit_err_cnt_q <= bit_err_cnt_d;
      end
   end

   assign bit_err_cnt = bit_err_cnt_q;
`else
   assign bit_err_cnt = '0;
`endif

   assign enc_y_in    = payload_q;
   assign dec_q0_0    = q0_0_q;
   assign dec_q0_1    = q0_1_q;
   assign dec_start   = (state_q == ST_DEC_START);
   assign busy        = (state_q == ST_ENC_WAIT) || (state_q == ST_DEC_START) ||
                        (state_q == ST_DEC_WAIT) || (state_q == ST_CHECK);
   assign done        = (state_q == ST_DONE);
   assign frame_cnt   = frame_cnt_q;
   assign pass_cnt    = pass_cnt_q;
   assign fail_cnt    = fail_cnt_q;
   assign timeout_cnt = timeout_cnt_q;

endmodule
